// File: rtl/fb_pkg.sv
// Shared widths and FSM state type for the OLED framebuffer arbiter.
package fb_pkg;
    localparam int FB_ADDR_W = 10;
    localparam int FB_DATA_W = 8;
    localparam int FB_DEPTH  = 1 << FB_ADDR_W;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } fb_state_e;
endpackage

// File: rtl/fb_ram.sv
// Single-port synchronous framebuffer RAM with a registered read.
// The output register only loads on a read, so data holds between reads.
module fb_ram
    import fb_pkg::*;
#(
    parameter int ADDR_W = FB_ADDR_W,
    parameter int DATA_W = FB_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              re,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rd_data
);
    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [DATA_W-1:0] rd_data_q, rd_data_d;

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end

    always_comb begin
        rd_data_d = rd_data_q;
        if (re) rd_data_d = mem[addr];
    end

    always_ff @(posedge clk) begin
        if (reset) rd_data_q <= '0;
        else       rd_data_q <= rd_data_d;
    end

    assign rd_data = rd_data_q;
endmodule

// File: rtl/oled_fb_arbiter.sv
// Framebuffer port arbiter: display read > bulk clear > round-robin client writes.
// Bulk clear engine is built only when FB_CLEAR_EN is defined.
module oled_fb_arbiter
    import fb_pkg::*;
#(
    parameter int N_WR   = 2,
    parameter int ADDR_W = FB_ADDR_W,
    parameter int DATA_W = FB_DATA_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     disp_req,
    input  logic [ADDR_W-1:0]        disp_addr,
    output logic [DATA_W-1:0]        disp_data,
    output logic                     disp_valid,
    input  logic [N_WR-1:0]          wr_req,
    input  logic [N_WR*ADDR_W-1:0]   wr_addr,
    input  logic [N_WR*DATA_W-1:0]   wr_data,
    output logic [N_WR-1:0]          wr_gnt,
    input  logic                     clear_req,
    input  logic [DATA_W-1:0]        clear_pattern,
    output logic                     clear_busy,
    output logic                     clear_done
);
    localparam int PTR_W = (N_WR > 1) ? $clog2(N_WR) : 1;

    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic              disp_valid_q, disp_valid_d;
    logic              clear_active;
    logic [ADDR_W-1:0] clear_addr;
    logic [DATA_W-1:0] clear_fill;

    logic              ram_re, ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [N_WR-1:0]   wr_gnt_c;
    logic              gnt_any;
    int                gnt_idx;
    int                idx;

    // Round-robin search from the pointer; the grant is suppressed whenever
    // a read or a clear owns the port so the request simply retries.
    always_comb begin
        gnt_any  = 1'b0;
        gnt_idx  = 0;
        idx      = 0;
        wr_gnt_c = '0;
        rr_ptr_d = rr_ptr_q;
        for (int off = 0; off < N_WR; off++) begin
            idx = (int'(rr_ptr_q) + off) % N_WR;
            if (!gnt_any && wr_req[idx]) begin
                gnt_any = 1'b1;
                gnt_idx = idx;
            end
        end
        if (reset || disp_req || clear_active) gnt_any = 1'b0;
        if (gnt_any) begin
            wr_gnt_c[gnt_idx] = 1'b1;
            rr_ptr_d          = PTR_W'((gnt_idx + 1) % N_WR);
        end
    end

    always_comb begin
        ram_re    = disp_req && !reset;
        ram_we    = 1'b0;
        ram_addr  = disp_addr;
        ram_wdata = '0;
        if (!disp_req && !reset) begin
            if (clear_active) begin
                ram_we    = 1'b1;
                ram_addr  = clear_addr;
                ram_wdata = clear_fill;
            end else if (gnt_any) begin
                ram_we    = 1'b1;
                ram_addr  = wr_addr[gnt_idx*ADDR_W +: ADDR_W];
                ram_wdata = wr_data[gnt_idx*DATA_W +: DATA_W];
            end
        end
        disp_valid_d = disp_req;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_q     <= '0;
            disp_valid_q <= 1'b0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            disp_valid_q <= disp_valid_d;
        end
    end

`ifdef FB_CLEAR_EN
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    fb_state_e         state_q, state_d;
    logic [ADDR_W-1:0] clear_addr_q, clear_addr_d;
    logic [DATA_W-1:0] clear_pat_q, clear_pat_d;
    logic              clear_busy_q, clear_busy_d;
    logic              clear_done_q, clear_done_d;

    always_comb begin
        state_d      = state_q;
        clear_addr_d = clear_addr_q;
        clear_pat_d  = clear_pat_q;
        clear_busy_d = clear_busy_q;
        clear_done_d = 1'b0;
        case (state_q)
            IDLE: if (clear_req) begin
                state_d      = CLEAR;
                clear_addr_d = '0;
                clear_pat_d  = clear_pattern;
                clear_busy_d = 1'b1;
            end
            CLEAR: if (!disp_req) begin
                if (clear_addr_q == LAST_ADDR) begin
                    state_d      = IDLE;
                    clear_busy_d = 1'b0;
                    clear_done_d = 1'b1;
                end else begin
                    clear_addr_d = clear_addr_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            clear_addr_q <= '0;
            clear_pat_q  <= '0;
            clear_busy_q <= 1'b0;
            clear_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            clear_addr_q <= clear_addr_d;
            clear_pat_q  <= clear_pat_d;
            clear_busy_q <= clear_busy_d;
            clear_done_q <= clear_done_d;
        end
    end

    assign clear_active = (state_q == CLEAR);
    assign clear_addr   = clear_addr_q;
    assign clear_fill   = clear_pat_q;
    assign clear_busy   = clear_busy_q;
    assign clear_done   = clear_done_q;
`else
    logic unused_clear;
    assign unused_clear = ^{clear_req, clear_pattern};
    assign clear_active = 1'b0;
    assign clear_addr   = '0;
    assign clear_fill   = '0;
    assign clear_busy   = 1'b0;
    assign clear_done   = 1'b0;
`endif

    fb_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ram (
        .clk     (clk),
        .reset   (reset),
        .re      (ram_re),
        .we      (ram_we),
        .addr    (ram_addr),
        .wdata   (ram_wdata),
        .rd_data (disp_data)
    );

    assign disp_valid = disp_valid_q;
    assign wr_gnt     = wr_gnt_c;
endmodule

// File: tb/tb_oled_fb_arbiter.sv
// Directed bench for oled_fb_arbiter (2 clients, 1024x8 framebuffer).
module tb_oled_fb_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        disp_req;
    logic [9:0]  disp_addr;
    logic [7:0]  disp_data;
    logic        disp_valid;
    logic [1:0]  wr_req;
    logic [19:0] wr_addr;
    logic [15:0] wr_data;
    logic [1:0]  wr_gnt;
    logic        clear_req;
    logic [7:0]  clear_pattern;
    logic        clear_busy;
    logic        clear_done;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    oled_fb_arbiter #(.N_WR(2), .ADDR_W(10), .DATA_W(8)) dut (
        .clk(clk), .reset(reset),
        .disp_req(disp_req), .disp_addr(disp_addr),
        .disp_data(disp_data), .disp_valid(disp_valid),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
        .clear_req(clear_req), .clear_pattern(clear_pattern),
        .clear_busy(clear_busy), .clear_done(clear_done)
    );

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    // One isolated display read; returns the valid flag and data of the response cycle.
    task automatic rd(input logic [9:0] a, output logic v, output logic [7:0] d);
        disp_req = 1'b1; disp_addr = a;
        tick();
        disp_req = 1'b0;
        settle();
        v = disp_valid; d = disp_data;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; disp_req = 1'b0; disp_addr = '0;
        wr_req = 2'b11; wr_addr = '0; wr_data = '0;
        clear_req = 1'b0; clear_pattern = '0;
        tick(); tick();
        settle();
        n_cmp++; if (disp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", disp_valid); end
        n_cmp++; if (disp_data !== 8'h00) begin n_bad++; $display("FAIL rst_data: got %h want 00", disp_data); end
        n_cmp++; if (wr_gnt !== 2'b00) begin n_bad++; $display("FAIL rst_gnt: got %b want 00", wr_gnt); end
        n_cmp++; if (clear_busy !== 1'b0 || clear_done !== 1'b0) begin n_bad++; $display("FAIL rst_clear: got busy %b done %b want 0 0", clear_busy, clear_done); end
        tick();
        reset = 1'b0; wr_req = 2'b00;
        settle();
        n_cmp++; if (disp_valid !== 1'b0 || wr_gnt !== 2'b00) begin n_bad++; $display("FAIL post_rst: got valid %b gnt %b want 0 00", disp_valid, wr_gnt); end
        tick();
    endtask

    task automatic test_write_read();
        wr_req = 2'b01; wr_addr[0 +: 10] = 10'd5; wr_data[0 +: 8] = 8'hA5;
        settle();
        n_cmp++; if (wr_gnt !== 2'b01) begin n_bad++; $display("FAIL wr_first_gnt: got %b want 01", wr_gnt); end
        tick();
        wr_req = 2'b00; disp_req = 1'b1; disp_addr = 10'd5;
        settle();
        n_cmp++; if (disp_valid !== 1'b0) begin n_bad++; $display("FAIL rd_early_valid: got %b want 0", disp_valid); end
        tick();
        disp_req = 1'b0;
        settle();
        n_cmp++; if (disp_valid !== 1'b1) begin n_bad++; $display("FAIL rd_valid: got %b want 1", disp_valid); end
        n_cmp++; if (disp_data !== 8'hA5) begin n_bad++; $display("FAIL rd_data: got %h want a5", disp_data); end
        tick();
        settle();
        n_cmp++; if (disp_valid !== 1'b0) begin n_bad++; $display("FAIL rd_pulse: got %b want 0", disp_valid); end
        n_cmp++; if (disp_data !== 8'hA5) begin n_bad++; $display("FAIL rd_hold: got %h want a5", disp_data); end
        tick();
    endtask

    // Pointer is 1 after the client-0 grant above, so client 1 goes first.
    task automatic test_round_robin();
        logic [1:0] exp_gnt [4];
        logic       v;
        logic [7:0] d;
        exp_gnt = '{2'b10, 2'b01, 2'b10, 2'b01};
        wr_req = 2'b11;
        wr_addr[0 +: 10] = 10'd10; wr_data[0 +: 8] = 8'h11;
        wr_addr[10 +: 10] = 10'd11; wr_data[8 +: 8] = 8'h22;
        for (int i = 0; i < 4; i++) begin
            settle();
            n_cmp++; if (wr_gnt !== exp_gnt[i]) begin n_bad++; $display("FAIL rr_gnt[%0d]: got %b want %b", i, wr_gnt, exp_gnt[i]); end
            tick();
        end
        wr_req = 2'b00;
        rd(10'd10, v, d);
        n_cmp++; if (v !== 1'b1 || d !== 8'h11) begin n_bad++; $display("FAIL rr_mem10: got v%b %h want v1 11", v, d); end
        rd(10'd11, v, d);
        n_cmp++; if (v !== 1'b1 || d !== 8'h22) begin n_bad++; $display("FAIL rr_mem11: got v%b %h want v1 22", v, d); end
    endtask

    task automatic test_collision();
        logic       v;
        logic [7:0] d;
        disp_req = 1'b1; disp_addr = 10'd10;
        wr_req = 2'b10; wr_addr[10 +: 10] = 10'd20; wr_data[8 +: 8] = 8'h5C;
        settle();
        n_cmp++; if (wr_gnt !== 2'b00) begin n_bad++; $display("FAIL col_gnt0: got %b want 00", wr_gnt); end
        tick();
        disp_req = 1'b0;
        settle();
        n_cmp++; if (disp_valid !== 1'b1 || disp_data !== 8'h11) begin n_bad++; $display("FAIL col_rd: got v%b %h want v1 11", disp_valid, disp_data); end
        n_cmp++; if (wr_gnt !== 2'b10) begin n_bad++; $display("FAIL col_gnt1: got %b want 10", wr_gnt); end
        tick();
        wr_req = 2'b00;
        rd(10'd20, v, d);
        n_cmp++; if (v !== 1'b1 || d !== 8'h5C) begin n_bad++; $display("FAIL col_mem: got v%b %h want v1 5c", v, d); end
    endtask

    task automatic test_withdraw();
        logic       v;
        logic [7:0] d;
        wr_req = 2'b01; wr_addr[0 +: 10] = 10'd30; wr_data[0 +: 8] = 8'h3C;
        settle();
        n_cmp++; if (wr_gnt !== 2'b01) begin n_bad++; $display("FAIL wd_setup_gnt: got %b want 01", wr_gnt); end
        tick();
        wr_data[0 +: 8] = 8'hEE;
        disp_req = 1'b1; disp_addr = 10'd30;
        settle();
        n_cmp++; if (wr_gnt !== 2'b00) begin n_bad++; $display("FAIL wd_gnt_blocked: got %b want 00", wr_gnt); end
        tick();
        disp_req = 1'b0; wr_req = 2'b00;
        settle();
        n_cmp++; if (wr_gnt !== 2'b00) begin n_bad++; $display("FAIL wd_gnt_after: got %b want 00", wr_gnt); end
        n_cmp++; if (disp_valid !== 1'b1 || disp_data !== 8'h3C) begin n_bad++; $display("FAIL wd_rd: got v%b %h want v1 3c", disp_valid, disp_data); end
        tick();
        rd(10'd30, v, d);
        n_cmp++; if (v !== 1'b1 || d !== 8'h3C) begin n_bad++; $display("FAIL wd_mem: got v%b %h want v1 3c", v, d); end
    endtask

    task automatic test_back_to_back();
        logic       v;
        logic [7:0] d;
        wr_req = 2'b10; wr_addr[10 +: 10] = 10'd40; wr_data[8 +: 8] = 8'h77;
        disp_req = 1'b1; disp_addr = 10'd5;
        settle();
        n_cmp++; if (wr_gnt !== 2'b00) begin n_bad++; $display("FAIL b2b_gnt0: got %b want 00", wr_gnt); end
        tick();
        disp_addr = 10'd10;
        settle();
        n_cmp++; if (wr_gnt !== 2'b00) begin n_bad++; $display("FAIL b2b_gnt1: got %b want 00", wr_gnt); end
        n_cmp++; if (disp_valid !== 1'b1 || disp_data !== 8'hA5) begin n_bad++; $display("FAIL b2b_rd0: got v%b %h want v1 a5", disp_valid, disp_data); end
        tick();
        disp_req = 1'b0;
        settle();
        n_cmp++; if (disp_valid !== 1'b1 || disp_data !== 8'h11) begin n_bad++; $display("FAIL b2b_rd1: got v%b %h want v1 11", disp_valid, disp_data); end
        n_cmp++; if (wr_gnt !== 2'b10) begin n_bad++; $display("FAIL b2b_gnt2: got %b want 10", wr_gnt); end
        tick();
        wr_req = 2'b00;
        rd(10'd40, v, d);
        n_cmp++; if (v !== 1'b1 || d !== 8'h77) begin n_bad++; $display("FAIL b2b_mem: got v%b %h want v1 77", v, d); end
    endtask

`ifdef FB_CLEAR_EN
    task automatic test_clear();
        logic       v;
        logic [7:0] d;
        int         busy_cnt;
        int         gnt_seen;
        bit         ended;
        busy_cnt = 0; gnt_seen = 0; ended = 1'b0;
        clear_req = 1'b1; clear_pattern = 8'hFF;
        tick();
        clear_req = 1'b0; clear_pattern = 8'h00;
        wr_req = 2'b01; wr_addr[0 +: 10] = 10'd600; wr_data[0 +: 8] = 8'h42;
        for (int i = 0; i < 1100; i++) begin
            settle();
            if (!clear_busy) begin ended = 1'b1; break; end
            busy_cnt++;
            if (wr_gnt !== 2'b00) gnt_seen++;
            tick();
        end
        n_cmp++; if (!ended) begin n_bad++; $display("FAIL clr_timeout: busy still %b after %0d cycles", clear_busy, busy_cnt); end
        n_cmp++; if (busy_cnt !== 1024) begin n_bad++; $display("FAIL clr_len: got %0d want 1024", busy_cnt); end
        n_cmp++; if (gnt_seen !== 0) begin n_bad++; $display("FAIL clr_gnt_blocked: got %0d grants want 0", gnt_seen); end
        n_cmp++; if (clear_done !== 1'b1) begin n_bad++; $display("FAIL clr_done: got %b want 1", clear_done); end
        n_cmp++; if (wr_gnt !== 2'b01) begin n_bad++; $display("FAIL clr_gnt_after: got %b want 01", wr_gnt); end
        tick();
        wr_req = 2'b00;
        settle();
        n_cmp++; if (clear_done !== 1'b0) begin n_bad++; $display("FAIL clr_done_pulse: got %b want 0", clear_done); end
        tick();
        rd(10'd0, v, d);
        n_cmp++; if (v !== 1'b1 || d !== 8'hFF) begin n_bad++; $display("FAIL clr_mem0: got v%b %h want v1 ff", v, d); end
        rd(10'd511, v, d);
        n_cmp++; if (v !== 1'b1 || d !== 8'hFF) begin n_bad++; $display("FAIL clr_mem511: got v%b %h want v1 ff", v, d); end
        rd(10'd1023, v, d);
        n_cmp++; if (v !== 1'b1 || d !== 8'hFF) begin n_bad++; $display("FAIL clr_mem1023: got v%b %h want v1 ff", v, d); end
        rd(10'd600, v, d);
        n_cmp++; if (v !== 1'b1 || d !== 8'h42) begin n_bad++; $display("FAIL clr_mem600: got v%b %h want v1 42", v, d); end
    endtask

    // 300 fill writes (addrs 0..299) land before reset; addr 300 keeps 0xFF.
    task automatic test_clear_abort();
        logic       v;
        logic [7:0] d;
        clear_req = 1'b1; clear_pattern = 8'h00;
        tick();
        clear_req = 1'b0;
        repeat (300) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        settle();
        n_cmp++; if (clear_busy !== 1'b0 || clear_done !== 1'b0) begin n_bad++; $display("FAIL abort_state: got busy %b done %b want 0 0", clear_busy, clear_done); end
        wr_req = 2'b11; wr_addr[0 +: 10] = 10'd700; wr_data[0 +: 8] = 8'h70;
        wr_addr[10 +: 10] = 10'd701; wr_data[8 +: 8] = 8'h71;
        settle();
        n_cmp++; if (wr_gnt !== 2'b01) begin n_bad++; $display("FAIL abort_gnt: got %b want 01", wr_gnt); end
        tick();
        wr_req = 2'b00;
        rd(10'd299, v, d);
        n_cmp++; if (v !== 1'b1 || d !== 8'h00) begin n_bad++; $display("FAIL abort_mem299: got v%b %h want v1 00", v, d); end
        rd(10'd300, v, d);
        n_cmp++; if (v !== 1'b1 || d !== 8'hFF) begin n_bad++; $display("FAIL abort_mem300: got v%b %h want v1 ff", v, d); end
        rd(10'd700, v, d);
        n_cmp++; if (v !== 1'b1 || d !== 8'h70) begin n_bad++; $display("FAIL abort_mem700: got v%b %h want v1 70", v, d); end
    endtask
`else
    task automatic test_clear();
        logic       v;
        logic [7:0] d;
        clear_req = 1'b1; clear_pattern = 8'hFF;
        tick();
        clear_req = 1'b0;
        settle();
        n_cmp++; if (clear_busy !== 1'b0 || clear_done !== 1'b0) begin n_bad++; $display("FAIL noclr_state: got busy %b done %b want 0 0", clear_busy, clear_done); end
        wr_req = 2'b01; wr_addr[0 +: 10] = 10'd50; wr_data[0 +: 8] = 8'h50;
        settle();
        n_cmp++; if (wr_gnt !== 2'b01) begin n_bad++; $display("FAIL noclr_gnt: got %b want 01", wr_gnt); end
        tick();
        wr_req = 2'b00;
        rd(10'd5, v, d);
        n_cmp++; if (v !== 1'b1 || d !== 8'hA5) begin n_bad++; $display("FAIL noclr_mem5: got v%b %h want v1 a5", v, d); end
        rd(10'd50, v, d);
        n_cmp++; if (v !== 1'b1 || d !== 8'h50) begin n_bad++; $display("FAIL noclr_mem50: got v%b %h want v1 50", v, d); end
    endtask

    task automatic test_clear_abort();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        wr_req = 2'b11; wr_addr[0 +: 10] = 10'd60; wr_data[0 +: 8] = 8'h60;
        settle();
        n_cmp++; if (wr_gnt !== 2'b01) begin n_bad++; $display("FAIL rst_ptr_gnt: got %b want 01", wr_gnt); end
        tick();
        wr_req = 2'b00;
    endtask
`endif

    initial begin
        test_reset();
        test_write_read();
        test_round_robin();
        test_collision();
        test_withdraw();
        test_back_to_back();
        test_clear();
        test_clear_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/oled_fb_arbiter.md
Name: oled_fb_arbiter

Overview:
- Owns the 1024x8 OLED framebuffer, organised as 128x64 pixels packed 8 vertical pixels per byte.
- Shares the framebuffer's single RAM port between three kinds of requester:
  - the display-refresh reader (the OLED serial driver fetching pixel bytes);
  - N_WR write clients (text engine, graphics/overlay engines);
  - an optional bulk clear engine.
- Sits between the OLED driver and the content generators. It replaces the direct combinational pixelAddress/pixelData coupling with a registered, arbitrated memory.

Parameters:
- N_WR, 2, number of write clients (1..4).
- ADDR_W, 10, framebuffer byte address width (depth = 2**ADDR_W).
- DATA_W, 8, framebuffer byte width.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- disp_req  in  1  display read request, single-cycle pulse.
- disp_addr  in  ADDR_W  read address, sampled when disp_req=1.
- disp_data  out  DATA_W  read data, valid when disp_valid=1, then held.
- disp_valid  out  1  one-cycle pulse, exactly 1 cycle after the accepted disp_req.
- wr_req  in  N_WR  per-client write request, level.
- wr_addr  in  N_WR*ADDR_W  client i address in slice [i*ADDR_W +: ADDR_W].
- wr_data  in  N_WR*DATA_W  client i data in slice [i*DATA_W +: DATA_W].
- wr_gnt  out  N_WR  one-hot, one-cycle grant; the write commits on that clock edge.
- clear_req  in  1  start bulk clear, pulse (FB_CLEAR_EN only).
- clear_pattern  in  DATA_W  fill byte, sampled with clear_req.
- clear_busy  out  1  clear in progress.
- clear_done  out  1  one-cycle pulse after the last clear write.

Behaviour:
- One RAM access per cycle.
  - Priority order: display read > clear write > client writes.
  - Client writes are arbitrated round-robin among themselves.
- Reset values:
  - disp_data=0, disp_valid=0, wr_gnt=0;
  - clear_busy=0, clear_done=0;
  - round-robin pointer=0, FSM=IDLE.
  - RAM contents are not reset.
- Read path: registered.
  - disp_req=1 at edge k -> RAM read at addr -> disp_valid=1 with data at k+1.
  - disp_data holds until the next valid.
  - A read always wins the port, including on back-to-back cycles. Back-to-back reads starve writers; the display contract is at most one disp_req per 2 cycles.
- Write handshake:
  - A client raises wr_req[i] and holds wr_addr/wr_data stable until it sees wr_gnt[i]=1.
  - The RAM write occurs in the grant cycle.
  - The client may drop wr_req or present the next word in the following cycle.
  - Dropping wr_req before grant withdraws the request; no write occurs.
- Round-robin:
  - The search starts at the pointer. Grant goes to the first requesting client, and the pointer moves to (granted+1) mod N_WR.
  - The pointer is unchanged on cycles with no client grant.
- Read/write collision:
  - disp_req together with any wr_req: the read is served and all wr_gnt=0.
  - Writers retry next cycle with no loss of request.
- Read-during-write to the same address in different cycles: the read returns the latest committed byte (write-before-read ordering across cycles).
- FSM states: IDLE, CLEAR (CLEAR exists only with FB_CLEAR_EN).
  - IDLE -> CLEAR on clear_req.
  - CLEAR -> IDLE after address 2**ADDR_W-1 is written.
- Reset in any state returns to IDLE immediately and aborts a clear in progress.

Optional Feature:
- Macro: FB_CLEAR_EN.
- Defined:
  - clear_req latches clear_pattern, sets clear_busy=1 and clear_addr=0.
  - Each cycle without disp_req writes the pattern to clear_addr, then clear_addr+1.
  - Client writes are blocked: wr_gnt=0 throughout.
  - After the final address: clear_busy=0 next cycle, with a clear_done pulse in that same cycle.
  - clear_req while busy is ignored.
  - With no display reads, a full clear takes 1024 cycles.
- Undefined: clear_req and clear_pattern are ignored; clear_busy=0 and clear_done=0 constantly. No clear counter or CLEAR state is synthesised.

Decomposition:
- Package fb_pkg holds:
  - FB_ADDR_W=10, FB_DATA_W=8, FB_DEPTH=1024;
  - the FSM state enum (IDLE, CLEAR).
- Sub-module fb_ram: single-port synchronous RAM, FB_DEPTH x FB_DATA_W, registered read, write-enable. It infers block RAM.
- Arbitration and the FSM stay in oled_fb_arbiter.

Test Plan:
- Write 0xA5 to addr 5 (client 0), then disp_req addr 5 -> wr_gnt[0] in the first cycle; disp_valid exactly 1 cycle after disp_req, disp_data=0xA5.
- Clients 0 and 1 both request continuously, with no display reads -> grants alternate 0,1,0,1; each client gets one grant per 2 cycles.
- disp_req in the same cycle as wr_req[1] -> wr_gnt=0 that cycle; disp_valid next cycle; wr_gnt[1] the cycle after; the write lands correctly.
- Client 0 raises then drops wr_req while the display holds the port -> no grant, and memory at that address is unchanged.
- FB_CLEAR_EN: clear_req with pattern 0xFF and no reads -> clear_busy for 1024 cycles, then a clear_done pulse; reads of 0, 511 and 1023 return 0xFF; wr_gnt stays 0 during the clear.
- Reset asserted mid-clear at addr 300 -> next cycle clear_busy=0 and no clear_done; the next client write is granted normally.
